imm_enc: RTL and testbench
==========================

Name: imm_enc

Overview:
- Instruction field encoder for RV32I/RV64I base formats; the inverse of the immediate decoder.
- Takes opcode, register indices, funct fields and a sign-extended DATA_WIDTH immediate.
- Produces the packed 32-bit instruction word and flags immediates the format cannot represent.
- Sits between the test-program/trace generator (or self-modifying-code path) and the instruction memory write port; 2-stage valid/ready pipeline.

Parameters:
- DATA_W, 32, immediate data width; legal values 32 or 64.
- INST_W, 32, instruction width; fixed at 32, other values unsupported.

Ports:
- i_imm_enc_clk  in  1  clock
- i_imm_enc_rst  in  1  asynchronous active-high reset
- i_imm_enc_valid  in  1  request valid
- o_imm_enc_ready  out  1  encoder can accept request
- i_imm_enc_opcode  in  7  base opcode
- i_imm_enc_funct3  in  3  funct3
- i_imm_enc_funct7  in  7  funct7; R-type and shift-immediate only
- i_imm_enc_rd  in  5  destination register index
- i_imm_enc_rs1  in  5  source register 1 index
- i_imm_enc_rs2  in  5  source register 2 index
- i_imm_enc_imm  in  DATA_W  sign-extended byte-offset immediate
- o_imm_enc_valid  out  1  encoded word valid
- i_imm_enc_ready  in  1  downstream accepts word
- o_imm_enc_inst  out  32  encoded instruction
- o_imm_enc_err  out  1  immediate unrepresentable or opcode unsupported; qualified by o_imm_enc_valid

Behaviour:
- Reset, async, active-high: S1/S2 valid cleared; o_imm_enc_valid=0, o_imm_enc_inst=0, o_imm_enc_err=0, o_imm_enc_ready=1.
- Reset mid-operation discards all in-flight entries; no partial output.
- Format classification from opcode:
  - R: 0110011
  - I: 1100111, 0000011, 0010011
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - anything else: BAD
- S1, on accept: registers fields, format and check result.
- S2: registers packed word and err.
- Latency: request accepted at edge N gives o_imm_enc_valid high after edge N+1. Throughput: one per cycle.
- Handshake:
  - Transfer occurs when valid && ready at a rising edge.
  - S1 advances when S2 is empty or i_imm_enc_ready=1.
  - o_imm_enc_ready = !s1_valid || s1_advance.
  - o_imm_enc_inst and o_imm_enc_err stay stable while o_imm_enc_valid && !i_imm_enc_ready.
  - Input accept and output drain in the same cycle are both legal; no bubble inserted.
- Packing:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - I shift (opcode 0010011, funct3 001 or 101): {funct7, imm[4:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - BAD: {25'b0, opcode}, err=1.
- Range rules; err=1 if violated, and the word is still packed from truncated bits:
  - I/S: imm[DATA_W-1:11] all equal.
  - I shift: imm[DATA_W-1:5]==0.
  - B: imm[DATA_W-1:12] all equal and imm[0]==0.
  - U: imm[11:0]==0 and imm[DATA_W-1:31] all equal.
  - J: imm[DATA_W-1:20] all equal and imm[0]==0.
  - R: imm ignored.

Optional Feature:
- Macro IMM_ENC_CHECK_EN.
- Defined: range checks above drive o_imm_enc_err.
- Undefined: checker is not instantiated; o_imm_enc_err=1 only for BAD opcode; immediates are silently truncated.
- Packing and latency are identical in both builds.

Decomposition:
- Package imm_enc_pkg holds:
  - opcode localparams OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP
  - enum fmt_e {FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD}
  - function opc2fmt
- One combinational sub-module, imm_enc_chk (fmt, imm -> err), guarded by IMM_ENC_CHECK_EN.

Test Plan:
- addi x1,x0,-1 (opc 0010011, f3 0, rd 1, imm 0xFFFFFFFF) -> inst 0xFFF00093, err 0, valid after 2 edges.
- sw x2,8(x1) -> 0x0020A423; beq x0,x0,-4 -> 0xFE000EE3; both err 0.
- jal x1,0x800 -> 0x001000EF; lui x5,imm 0x12345000 -> 0x123452B7.
- addi imm 2048 -> err 1 with check enabled, err 0 without; beq imm 6 -> err 0; beq imm 5 -> err 1; opcode 0x7F -> inst 0x0000007F, err 1.
- Backpressure: 4 back-to-back requests with i_imm_enc_ready low for 3 cycles -> o_imm_enc_ready drops after 2 accepts; outputs held stable; all 4 words emitted in order with no loss or duplication.
- Assert i_imm_enc_rst with 2 entries in flight -> o_imm_enc_valid=0 immediately; first request after release emitted normally.

Source files
------------

// File: rtl/imm_enc_pkg.sv
// rtl/imm_enc_pkg.sv - opcode constants, instruction format enum and opcode classifier for imm_enc
package imm_enc_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  // funct3 is needed because slli/srli/srai share OP-IMM but pack a 5-bit shamt
  function automatic fmt_e opc2fmt(input logic [6:0] opc, input logic [2:0] f3);
    fmt_e f;
    case (opc)
      OPC_OP:                      f = FMT_R;
      OPC_JALR, OPC_LOAD:          f = FMT_I;
      OPC_OPIMM:                   f = (f3 == 3'b001 || f3 == 3'b101) ? FMT_ISH : FMT_I;
      OPC_STORE:                   f = FMT_S;
      OPC_BRANCH:                  f = FMT_B;
      OPC_LUI, OPC_AUIPC:          f = FMT_U;
      OPC_JAL:                     f = FMT_J;
      default:                     f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_enc_chk.sv
// rtl/imm_enc_chk.sv - combinational immediate range checker, one flag per format
module imm_enc_chk
  import imm_enc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        i_fmt,
  input  logic [DATA_W-1:0] i_imm,
  output logic              o_err
);

  logic w_hi11_ok, w_hi12_ok, w_hi20_ok, w_hi31_ok, w_hi5_zero;

  // "all equal" means the dropped upper bits are a pure sign extension
  assign w_hi11_ok  = (&i_imm[DATA_W-1:11]) | ~(|i_imm[DATA_W-1:11]);
  assign w_hi12_ok  = (&i_imm[DATA_W-1:12]) | ~(|i_imm[DATA_W-1:12]);
  assign w_hi20_ok  = (&i_imm[DATA_W-1:20]) | ~(|i_imm[DATA_W-1:20]);
  assign w_hi31_ok  = (&i_imm[DATA_W-1:31]) | ~(|i_imm[DATA_W-1:31]);
  assign w_hi5_zero = ~(|i_imm[DATA_W-1:5]);

  always_comb begin
    o_err = 1'b0;
    case (fmt_e'(i_fmt))
      FMT_I, FMT_S: o_err = !w_hi11_ok;
      FMT_ISH:      o_err = !w_hi5_zero;
      FMT_B:        o_err = !w_hi12_ok || i_imm[0];
      FMT_U:        o_err = (|i_imm[11:0]) || !w_hi31_ok;
      FMT_J:        o_err = !w_hi20_ok || i_imm[0];
      default:      o_err = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_enc.sv
// rtl/imm_enc.sv - 2-stage RV32I/RV64I instruction encoder; IMM_ENC_CHECK_EN enables immediate range errors
module imm_enc
  import imm_enc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int INST_W = 32
) (
  input  logic              i_imm_enc_clk,
  input  logic              i_imm_enc_rst,
  input  logic              i_imm_enc_valid,
  output logic              o_imm_enc_ready,
  input  logic [6:0]        i_imm_enc_opcode,
  input  logic [2:0]        i_imm_enc_funct3,
  input  logic [6:0]        i_imm_enc_funct7,
  input  logic [4:0]        i_imm_enc_rd,
  input  logic [4:0]        i_imm_enc_rs1,
  input  logic [4:0]        i_imm_enc_rs2,
  input  logic [DATA_W-1:0] i_imm_enc_imm,
  output logic              o_imm_enc_valid,
  input  logic              i_imm_enc_ready,
  output logic [INST_W-1:0] o_imm_enc_inst,
  output logic              o_imm_enc_err
);

  fmt_e        w_fmt;
  logic        w_chk_err;
  logic        w_accept, w_s1_adv;
  logic [31:0] w_pack;

  logic        r_s1_valid, r_s1_err;
  fmt_e        r_s1_fmt;
  logic [6:0]  r_s1_opc, r_s1_f7;
  logic [2:0]  r_s1_f3;
  logic [4:0]  r_s1_rd, r_s1_rs1, r_s1_rs2;
  logic [31:0] r_s1_imm;

  logic              r_s2_valid, r_s2_err;
  logic [INST_W-1:0] r_s2_inst;

  assign w_fmt = opc2fmt(i_imm_enc_opcode, i_imm_enc_funct3);

`ifdef IMM_ENC_CHECK_EN
  imm_enc_chk #(.DATA_W(DATA_W)) u_chk (
    .i_fmt (w_fmt),
    .i_imm (i_imm_enc_imm),
    .o_err (w_chk_err)
  );
`else
  assign w_chk_err = 1'b0;
`endif

  assign w_s1_adv        = r_s1_valid && (!r_s2_valid || i_imm_enc_ready);
  assign o_imm_enc_ready = !r_s1_valid || w_s1_adv;
  assign w_accept        = i_imm_enc_valid && o_imm_enc_ready;

  always_ff @(posedge i_imm_enc_clk or posedge i_imm_enc_rst) begin
    if (i_imm_enc_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_fmt   <= FMT_BAD;
      r_s1_opc   <= '0;
      r_s1_f7    <= '0;
      r_s1_f3    <= '0;
      r_s1_rd    <= '0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
      r_s1_imm   <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_err   <= (w_fmt == FMT_BAD) || w_chk_err;
      r_s1_fmt   <= w_fmt;
      r_s1_opc   <= i_imm_enc_opcode;
      r_s1_f7    <= i_imm_enc_funct7;
      r_s1_f3    <= i_imm_enc_funct3;
      r_s1_rd    <= i_imm_enc_rd;
      r_s1_rs1   <= i_imm_enc_rs1;
      r_s1_rs2   <= i_imm_enc_rs2;
      r_s1_imm   <= i_imm_enc_imm[31:0];
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_comb begin
    w_pack = {25'b0, r_s1_opc};
    case (r_s1_fmt)
      FMT_R:   w_pack = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_opc};
      FMT_I:   w_pack = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_opc};
      FMT_ISH: w_pack = {r_s1_f7, r_s1_imm[4:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_opc};
      FMT_S:   w_pack = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], r_s1_opc};
      FMT_B:   w_pack = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                         r_s1_imm[4:1], r_s1_imm[11], r_s1_opc};
      FMT_U:   w_pack = {r_s1_imm[31:12], r_s1_rd, r_s1_opc};
      FMT_J:   w_pack = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                         r_s1_rd, r_s1_opc};
      default: w_pack = {25'b0, r_s1_opc};
    endcase
  end

  // S2 only reloads on advance, so inst/err hold while the consumer stalls
  always_ff @(posedge i_imm_enc_clk or posedge i_imm_enc_rst) begin
    if (i_imm_enc_rst) begin
      r_s2_valid <= 1'b0;
      r_s2_err   <= 1'b0;
      r_s2_inst  <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_err   <= r_s1_err;
      r_s2_inst  <= w_pack;
    end else if (i_imm_enc_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign o_imm_enc_valid = r_s2_valid;
  assign o_imm_enc_inst  = r_s2_inst;
  assign o_imm_enc_err   = r_s2_err;

endmodule

// File: tb/tb_imm_enc.sv
// tb/tb_imm_enc.sv - table-driven bench for imm_enc; expected err follows IMM_ENC_CHECK_EN
module tb_imm_enc;

`ifdef IMM_ENC_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, o_valid, i_ready, o_err;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, o_inst;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  imm_enc #(.DATA_W(32), .INST_W(32)) dut (
    .i_imm_enc_clk    (clk),
    .i_imm_enc_rst    (rst),
    .i_imm_enc_valid  (i_valid),
    .o_imm_enc_ready  (o_ready),
    .i_imm_enc_opcode (opc),
    .i_imm_enc_funct3 (f3),
    .i_imm_enc_funct7 (f7),
    .i_imm_enc_rd     (rd),
    .i_imm_enc_rs1    (rs1),
    .i_imm_enc_rs2    (rs2),
    .i_imm_enc_imm    (imm),
    .o_imm_enc_valid  (o_valid),
    .i_imm_enc_ready  (i_ready),
    .o_imm_enc_inst   (o_inst),
    .o_imm_enc_err    (o_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    opc = v.opc; f3 = v.f3; f7 = v.f7;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
  endtask

  // starts and ends at a negedge with the pipeline empty
  task automatic run_vec(input int k);
    drive(vecs[k]);
    i_valid = 1'b1;
    i_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_ready", k), {31'b0, o_ready}, 32'd1);
    @(negedge clk);
    i_valid = 1'b0;
    chk($sformatf("v%0d_valid_n1", k), {31'b0, o_valid}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_valid_n2", k), {31'b0, o_valid}, 32'd1);
    chk($sformatf("v%0d_inst", k), o_inst, vecs[k].exp_inst);
    chk($sformatf("v%0d_err", k), {31'b0, o_err}, {31'b0, vecs[k].exp_err});
    @(negedge clk);
  endtask

  initial begin
    int sent, got;
    logic [31:0] held;

    vecs[0]  = '{7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
    vecs[1]  = '{7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'h00000008, 32'h0020A423, 1'b0};
    vecs[2]  = '{7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
    vecs[3]  = '{7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1'b0};
    vecs[4]  = '{7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0};
    vecs[5]  = '{7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h80000093, CHK};
    vecs[6]  = '{7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h00000006, 32'h00000363, 1'b0};
    vecs[7]  = '{7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h00000005, 32'h00000263, CHK};
    vecs[8]  = '{7'h7F, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'h00000000, 32'h0000007F, 1'b1};
    vecs[9]  = '{7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF, 32'h002081B3, 1'b0};
    vecs[10] = '{7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'h00000000, 32'h402081B3, 1'b0};
    vecs[11] = '{7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'h00000003, 32'h40315093, 1'b0};
    vecs[12] = '{7'h13, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 32'h00000020, 32'h00011093, CHK};
    vecs[13] = '{7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'h123452B7, CHK};
    vecs[14] = '{7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00100000, 32'h800000EF, CHK};
    vecs[15] = '{7'h17, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFF000, 32'hFFFFF017, 1'b0};
    vecs[16] = '{7'h03, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFF800, 32'h80012083, 1'b0};
    vecs[17] = '{7'h67, 3'd0, 7'h00, 5'd0, 5'd1, 5'd0, 32'h00000000, 32'h00008067, 1'b0};
    vecs[18] = '{7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h000007FF, 32'h7FF00093, 1'b0};

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_err", {31'b0, o_err}, 32'd0);
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < NVEC; k++) run_vec(k);

    // backpressure: consumer stalls while four requests are offered back to back
    sent = 0; got = 0; held = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      i_ready = (c >= 5);
      if (sent < 4) begin
        drive(vecs[sent]);
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (c == 2) begin
        chk("bp_ready_drop", {31'b0, o_ready}, 32'd0);
        chk("bp_accepts", sent, 32'd2);
        held = o_inst;
      end
      if (c == 3 || c == 4) begin
        chk($sformatf("bp_hold_valid_c%0d", c), {31'b0, o_valid}, 32'd1);
        chk($sformatf("bp_hold_inst_c%0d", c), o_inst, held);
      end
      if (i_valid && o_ready) sent++;
      if (o_valid && i_ready) begin
        chk($sformatf("bp_out%0d", got), o_inst, vecs[got].exp_inst);
        got++;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    chk("bp_count", got, 32'd4);
    #1;
    chk("bp_no_dup", {31'b0, o_valid}, 32'd0);
    @(negedge clk);

    // reset with two entries in flight
    drive(vecs[0]); i_valid = 1'b1; i_ready = 1'b0;
    @(negedge clk);
    drive(vecs[1]);
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk("inflight_valid", {31'b0, o_valid}, 32'd1);
    chk("inflight_ready", {31'b0, o_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, o_valid}, 32'd0);
    chk("midrst_inst", o_inst, 32'd0);
    chk("midrst_ready", {31'b0, o_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    chk("postrst_empty", {31'b0, o_valid}, 32'd0);
    run_vec(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
